// File: rtl/shot_clock_pkg.sv
// Shared types and reload codes for the shot-clock controller.
package shot_clock_pkg;

  localparam int unsigned LOAD_W = 5;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  localparam logic [LOAD_W-1:0] LOAD_24   = 5'b11000;
  localparam logic [LOAD_W-1:0] LOAD_14   = 5'b01110;
  localparam logic [LOAD_W-1:0] LOAD_NONE = 5'b00000;

endpackage

// File: rtl/shot_clock_control_if.sv
// Referee panel <-> shot-clock controller signal bundle.
interface shot_clock_control_if;
  import shot_clock_pkg::*;

  logic              btn_24;
  logic              btn_14;
  logic              btn_run;
  logic              buzzer_in;
  logic              tick_out;
  logic [LOAD_W-1:0] load_cmd;
  logic              chave_parar;
  logic              horn;
  logic              running;

  modport master (
    output btn_24, btn_14, btn_run, buzzer_in,
    input  tick_out, load_cmd, chave_parar, horn, running
  );

  modport slave (
    input  btn_24, btn_14, btn_run, buzzer_in,
    output tick_out, load_cmd, chave_parar, horn, running
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter; emits a one-cycle pulse on a
// debounced press, nothing on release.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only advances while the synced level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/shot_clock_control.sv
// Shot-clock controller: tick divider, held reload code, run/expiry FSM and
// horn sequencing for the downstream countdown.
module shot_clock_control
  import shot_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HORN_SECONDS    = 2
) (
  input  logic                 clock_in,
  input  logic                 reset,
  shot_clock_control_if.slave  bus
);
  localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
  localparam int unsigned HALF   = DIV / 2;
  localparam int unsigned DIV_W  = $clog2(DIV);
  localparam int unsigned HORN_W = $clog2(HORN_SECONDS + 1);

  logic press_24, press_14, press_run;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_24 (
    .clk_i(clock_in), .rst_i(reset), .btn_i(bus.btn_24), .press_o(press_24));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_14 (
    .clk_i(clock_in), .rst_i(reset), .btn_i(bus.btn_14), .press_o(press_14));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk_i(clock_in), .rst_i(reset), .btn_i(bus.btn_run), .press_o(press_run));

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [LOAD_W-1:0] pending_q, pending_d;
  logic [LOAD_W-1:0] load_q, load_d;
  state_e            state_q, state_d;
  logic [HORN_W-1:0] horn_cnt_q, horn_cnt_d;
  logic              buz_sync1_q, buz_sync2_q, buz_prev_q;
  logic              horn_q, horn_d;
  logic              run_q, run_d;
  logic              chave_q, chave_d;
  logic              tick_rise, buzz_rise, reload_press;

  always_comb begin
    tick_rise    = (div_q == DIV_W'(DIV - 1));
    div_d        = tick_rise ? '0 : div_q + DIV_W'(1);
    tick_d       = (div_q < DIV_W'(HALF));
    buzz_rise    = buz_sync2_q & ~buz_prev_q;
    reload_press = press_24 | press_14;

    // A press arriving on a tick_rise is kept for the next period, not cleared.
    pending_d = pending_q;
    load_d    = load_q;
    if (tick_rise) begin
      load_d    = pending_q;
      pending_d = LOAD_NONE;
    end
    if (press_24)      pending_d = LOAD_24;
    else if (press_14) pending_d = LOAD_14;

    state_d    = state_q;
    horn_cnt_d = horn_cnt_q;
    case (state_q)
      STOPPED: begin
        if (buzz_rise) begin
          state_d    = EXPIRED;
          horn_cnt_d = '0;
        end else if (press_run) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (buzz_rise) begin
          state_d    = EXPIRED;
          horn_cnt_d = '0;
        end else if (press_run) begin
          state_d = STOPPED;
        end
      end
      EXPIRED: begin
        if (reload_press) begin
          state_d = STOPPED;
        end else if (tick_rise) begin
          if (horn_cnt_q == HORN_W'(HORN_SECONDS - 1)) state_d = STOPPED;
          else horn_cnt_d = horn_cnt_q + HORN_W'(1);
        end
      end
      default: state_d = STOPPED;
    endcase

    run_d   = (state_d == RUNNING);
    horn_d  = (state_d == EXPIRED);
    chave_d = run_d && (load_d == LOAD_NONE);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      div_q       <= '0;
      tick_q      <= 1'b0;
      pending_q   <= LOAD_NONE;
      load_q      <= LOAD_NONE;
      state_q     <= STOPPED;
      horn_cnt_q  <= '0;
      buz_sync1_q <= 1'b0;
      buz_sync2_q <= 1'b0;
      buz_prev_q  <= 1'b0;
      horn_q      <= 1'b0;
      run_q       <= 1'b0;
      chave_q     <= 1'b0;
    end else begin
      div_q       <= div_d;
      tick_q      <= tick_d;
      pending_q   <= pending_d;
      load_q      <= load_d;
      state_q     <= state_d;
      horn_cnt_q  <= horn_cnt_d;
      buz_sync1_q <= bus.buzzer_in;
      buz_sync2_q <= buz_sync1_q;
      buz_prev_q  <= buz_sync2_q;
      horn_q      <= horn_d;
      run_q       <= run_d;
      chave_q     <= chave_d;
    end
  end

  assign bus.tick_out    = tick_q;
  assign bus.load_cmd    = load_q;
  assign bus.chave_parar = chave_q;
  assign bus.horn        = horn_q;
  assign bus.running     = run_q;
endmodule

// File: tb/tb_shot_clock_control.sv
// Scoreboard bench: stimulus queues each expected change of the
// {running, horn, chave_parar, load_cmd} tuple; a monitor checks every change.
module tb_shot_clock_control;
  import shot_clock_pkg::*;

  logic clk = 1'b0;
  logic rst;

  shot_clock_control_if bus ();

  shot_clock_control #(
    .CLK_HZ(8), .TICK_HZ(1), .DEBOUNCE_CYCLES(3), .HORN_SECONDS(2)
  ) dut (
    .clock_in(clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       running;
    logic       horn;
    logic       chave;
    logic [4:0] load;
  } obs_t;

  typedef struct {
    string name;
    obs_t  obs;
    int    prev_dur;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Edges since the last reset edge; stimulus is scheduled against this.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic expect_change(input string n, input logic r, input logic h,
                               input logic c, input logic [4:0] l, input int d);
    exp_t e;
    e.name     = n;
    e.obs      = {r, h, c, l};
    e.prev_dur = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Tuple monitor
  initial begin
    obs_t last, cur;
    int   elapsed;
    bit   rst_edge;
    exp_t e;
    last    = '0;
    elapsed = 0;
    forever begin
      @(posedge clk);
      rst_edge = rst;
      @(negedge clk);
      cur = {bus.running, bus.horn, bus.chave_parar, bus.load_cmd};
      if (rst_edge) begin
        checks++;
        if (cur != '0) begin
          errors++;
          $display("FAIL reset_outputs: got run=%0b horn=%0b chave=%0b load=%05b, want all 0",
                   cur.running, cur.horn, cur.chave, cur.load);
        end
        last    = '0;
        elapsed = 0;
      end else if (cur == last) begin
        elapsed++;
      end else begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change at cyc %0d: got run=%0b horn=%0b chave=%0b load=%05b",
                   cyc, cur.running, cur.horn, cur.chave, cur.load);
        end else begin
          e = sb_q.pop_front();
          if (cur != e.obs) begin
            errors++;
            $display("FAIL %s: got run=%0b horn=%0b chave=%0b load=%05b, want run=%0b horn=%0b chave=%0b load=%05b",
                     e.name, cur.running, cur.horn, cur.chave, cur.load,
                     e.obs.running, e.obs.horn, e.obs.chave, e.obs.load);
          end
          if (e.prev_dur != 0) begin
            checks++;
            if (elapsed != e.prev_dur) begin
              errors++;
              $display("FAIL %s_timing: previous state lasted %0d cycles, want %0d",
                       e.name, elapsed, e.prev_dur);
            end
          end
        end
        last    = cur;
        elapsed = 1;
      end
    end
  end

  // tick_out model: high for 4 cycles then low for 4, restarting after reset.
  initial begin
    int k;
    bit rst_edge;
    logic want;
    k = 0;
    forever begin
      @(posedge clk);
      rst_edge = rst;
      @(negedge clk);
      want = rst_edge ? 1'b0 : ((k % 8) < 4);
      checks++;
      if (bus.tick_out !== want) begin
        errors++;
        $display("FAIL tick_out at k=%0d: got %0b, want %0b", k, bus.tick_out, want);
      end
      k = rst_edge ? 0 : k + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.btn_24    = 1'b0;
    bus.btn_14    = 1'b0;
    bus.btn_run   = 1'b0;
    bus.buzzer_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Reload 24 while stopped: visible for one full tick period, no run.
    expect_change("load24_stopped", 0, 0, 0, LOAD_24,   7);
    expect_change("load24_clear",   0, 0, 0, LOAD_NONE, 8);
    wait_until(1);  bus.btn_24 = 1'b1;
    wait_until(7);  bus.btn_24 = 1'b0;

    // Start running.
    expect_change("run_start", 1, 0, 1, LOAD_NONE, 14);
    wait_until(24); bus.btn_run = 1'b1;
    wait_until(28); bus.btn_run = 1'b0;

    // Reload 14 while running: run enable drops only during the reload window.
    expect_change("load14_running", 1, 0, 0, LOAD_14,   10);
    expect_change("load14_clear",   1, 0, 1, LOAD_NONE, 8);
    wait_until(33); bus.btn_14 = 1'b1;
    wait_until(37); bus.btn_14 = 1'b0;

    // Both reload buttons together: 24 wins.
    expect_change("both_24_wins", 1, 0, 0, LOAD_24,   8);
    expect_change("both_clear",   1, 0, 1, LOAD_NONE, 8);
    wait_until(48); bus.btn_24 = 1'b1; bus.btn_14 = 1'b1;
    wait_until(52); bus.btn_24 = 1'b0; bus.btn_14 = 1'b0;

    // Buzzer while running: horn for two tick_rises, run press ignored.
    expect_change("horn_on",  0, 1, 0, LOAD_NONE, 5);
    expect_change("horn_off", 0, 0, 0, LOAD_NONE, 11);
    wait_until(66); bus.buzzer_in = 1'b1;
    wait_until(70); bus.btn_run   = 1'b1;
    wait_until(74); bus.btn_run   = 1'b0;
    wait_until(85); bus.buzzer_in = 1'b0;

    // Buzzer from stopped, then reload cuts the horn short.
    expect_change("horn2_on",         0, 1, 0, LOAD_NONE, 13);
    expect_change("horn2_reload_end", 0, 0, 0, LOAD_NONE, 7);
    wait_until(90); bus.buzzer_in = 1'b1;
    wait_until(94); bus.btn_24    = 1'b1;
    wait_until(98); bus.btn_24    = 1'b0;

    // Reset mid-period with the 24 reload still pending: it must be lost.
    wait_until(101); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.buzzer_in = 1'b0;
    wait_until(30);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected changes never seen, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
